// File: rtl/mul_accumulator.sv
// Accumulates a batch of unsigned multiplier products into a wide sum and
// presents the sum, term count and sticky overflow over a valid/ready handshake.
module mul_accumulator #(
  parameter int PROD_W    = 64,
  parameter int ACC_W     = 72,
  parameter int MAX_TERMS = 16,
  parameter int CNT_W     = $clog2(MAX_TERMS + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [PROD_W-1:0] in_prod,
  input  logic              in_last,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ACC_W-1:0]  out_sum,
  output logic [CNT_W-1:0]  out_count,
  output logic              out_ovf
);

  typedef enum logic {ACCUM, HOLD} state_t;

  state_t             state, state_nxt;
  logic [ACC_W-1:0]   acc;
  logic [CNT_W-1:0]   cnt;
  logic               ovf;
  logic [ACC_W:0]     sum;
  logic [CNT_W-1:0]   cnt_inc;
  logic               xfer;
  logic               close;

  // One extra bit on top of the accumulator captures the carry-out for ovf.
  function automatic logic [ACC_W:0] acc_add(input logic [ACC_W-1:0] a,
                                             input logic [PROD_W-1:0] p);
    return {1'b0, a} + {{(ACC_W + 1 - PROD_W){1'b0}}, p};
  endfunction

  assign in_ready = (state == ACCUM) && !clr && !rst;
  assign xfer     = in_valid && in_ready;
  assign sum      = acc_add(acc, in_prod);
  assign cnt_inc  = cnt + 1'b1;
  assign close    = xfer && (in_last || (cnt_inc == CNT_W'(MAX_TERMS)));

  always_ff @(posedge clk) begin
    if (rst) state <= ACCUM;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ACCUM:   if (close) state_nxt = HOLD;
      HOLD:    if (clr || out_ready) state_nxt = ACCUM;
      default: state_nxt = ACCUM;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      acc       <= '0;
      cnt       <= '0;
      ovf       <= 1'b0;
      out_sum   <= '0;
      out_count <= '0;
      out_ovf   <= 1'b0;
      out_valid <= 1'b0;
    end else if (state == ACCUM) begin
      if (clr) begin
        acc <= '0;
        cnt <= '0;
        ovf <= 1'b0;
      end else if (xfer) begin
        acc <= sum[ACC_W-1:0];
        cnt <= cnt_inc;
        ovf <= ovf | sum[ACC_W];
        if (close) begin
          out_sum   <= sum[ACC_W-1:0];
          out_count <= cnt_inc;
          out_ovf   <= ovf | sum[ACC_W];
          out_valid <= 1'b1;
        end
      end
    end else if (clr || out_ready) begin
      // Result taken or dropped: the output fields stay put, only valid falls.
      out_valid <= 1'b0;
      acc       <= '0;
      cnt       <= '0;
      ovf       <= 1'b0;
    end
  end

endmodule

// File: tb/tb_mul_accumulator.sv
// Directed bench for mul_accumulator: a default instance plus an ACC_W=64
// instance sharing the same stimulus, so carry-out into out_ovf is reachable.
module tb_mul_accumulator;

  logic        clk = 1'b0;
  logic        rst, clr, in_valid, in_last, out_ready;
  logic [63:0] in_prod;

  logic        in_ready, out_valid, out_ovf;
  logic [71:0] out_sum;
  logic [4:0]  out_count;

  logic        in_ready64, out_valid64, out_ovf64;
  logic [63:0] out_sum64;
  logic [4:0]  out_count64;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  mul_accumulator dut (
    .clk(clk), .rst(rst), .clr(clr), .in_valid(in_valid), .in_ready(in_ready),
    .in_prod(in_prod), .in_last(in_last), .out_valid(out_valid),
    .out_ready(out_ready), .out_sum(out_sum), .out_count(out_count),
    .out_ovf(out_ovf)
  );

  mul_accumulator #(.ACC_W(64)) dut64 (
    .clk(clk), .rst(rst), .clr(clr), .in_valid(in_valid), .in_ready(in_ready64),
    .in_prod(in_prod), .in_last(in_last), .out_valid(out_valid64),
    .out_ready(out_ready), .out_sum(out_sum64), .out_count(out_count64),
    .out_ovf(out_ovf64)
  );

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [63:0] p, input logic last);
    in_valid = 1'b1;
    in_prod  = p;
    in_last  = last;
    #1;
    chk("send_in_ready", in_ready, 1'b1);
    tick();
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic take();
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk("take_out_valid", out_valid, 1'b0);
    #1;
    chk("take_in_ready", in_ready, 1'b1);
  endtask

  initial begin
    rst = 1'b1; clr = 1'b0; in_valid = 1'b0; in_last = 1'b0;
    out_ready = 1'b0; in_prod = '0;

    // Reset held three cycles
    for (int i = 0; i < 3; i++) begin
      tick();
      #1;
      chk("rst_in_ready", in_ready, 1'b0);
    end
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_out_sum", out_sum, 72'h0);
    chk("rst_out_count", out_count, 5'd0);
    chk("rst_out_ovf", out_ovf, 1'b0);
    rst = 1'b0;
    #1;
    chk("post_rst_in_ready", in_ready, 1'b1);

    // Basic batch
    send(64'd5, 1'b0);
    send(64'd7, 1'b0);
    chk("basic_no_early_valid", out_valid, 1'b0);
    send(64'hFFFFFFFF_00000001, 1'b1);
    chk("basic_out_valid", out_valid, 1'b1);
    chk("basic_out_sum", out_sum, 72'h00_FFFFFFFF_0000000D);
    chk("basic_out_count", out_count, 5'd3);
    chk("basic_out_ovf", out_ovf, 1'b0);

    // Backpressure: offered terms must not be absorbed while holding
    in_valid = 1'b1; in_prod = 64'd123; in_last = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk("bp_in_ready", in_ready, 1'b0);
      tick();
      chk("bp_out_valid", out_valid, 1'b1);
      chk("bp_out_sum", out_sum, 72'h00_FFFFFFFF_0000000D);
      chk("bp_out_count", out_count, 5'd3);
    end
    in_valid = 1'b0; in_last = 1'b0;
    take();

    // Overflow on the 64-bit instance; the 72-bit one keeps the carry
    send(64'hFFFFFFFF_FFFFFFFF, 1'b0);
    send(64'h2, 1'b1);
    chk("ovf64_out_sum", out_sum64, 64'd1);
    chk("ovf64_out_count", out_count64, 5'd2);
    chk("ovf64_out_ovf", out_ovf64, 1'b1);
    chk("ovf72_out_sum", out_sum, 72'h01_00000000_00000001);
    chk("ovf72_out_ovf", out_ovf, 1'b0);
    take();
    send(64'd4, 1'b1);
    chk("ovf64_next_sum", out_sum64, 64'd4);
    chk("ovf64_next_ovf", out_ovf64, 1'b0);
    take();

    // Auto-close on the sixteenth term
    for (int i = 0; i < 16; i++) begin
      chk("auto_no_early_valid", out_valid, 1'b0);
      send(64'd1, 1'b0);
    end
    chk("auto_out_valid", out_valid, 1'b1);
    chk("auto_out_sum", out_sum, 72'd16);
    chk("auto_out_count", out_count, 5'd16);
    in_valid = 1'b1; in_prod = 64'd1;
    for (int i = 0; i < 2; i++) begin
      #1;
      chk("auto_in_ready", in_ready, 1'b0);
      tick();
    end
    in_valid = 1'b0;

    // clr together with out_ready in HOLD drops the result and clears acc
    clr = 1'b1; out_ready = 1'b1;
    tick();
    clr = 1'b0; out_ready = 1'b0;
    chk("clr_hold_out_valid", out_valid, 1'b0);
    send(64'd3, 1'b1);
    chk("clr_hold_next_sum", out_sum, 72'd3);
    chk("clr_hold_next_count", out_count, 5'd1);
    take();

    // Abort mid-batch; the concurrent term must be refused
    send(64'd100, 1'b0);
    send(64'd200, 1'b0);
    clr = 1'b1; in_valid = 1'b1; in_prod = 64'd50;
    #1;
    chk("abort_in_ready", in_ready, 1'b0);
    tick();
    clr = 1'b0; in_valid = 1'b0;
    send(64'd9, 1'b1);
    chk("abort_out_valid", out_valid, 1'b1);
    chk("abort_out_sum", out_sum, 72'd9);
    chk("abort_out_count", out_count, 5'd1);

    // Reset while a result is pending
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("rst_hold_out_valid", out_valid, 1'b0);
    chk("rst_hold_out_sum", out_sum, 72'd0);
    chk("rst_hold_out_count", out_count, 5'd0);
    #1;
    chk("rst_hold_in_ready", in_ready, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
